reorder_buffer: RTL and testbench

//  Circular in-order reorder buffer between Dispatch/execution units and the Regfile.

---
 rtl/reorder_buffer_pkg.sv | 25 ++
 rtl/reorder_buffer_if.sv | 46 ++++
 rtl/reorder_buffer_ring_ctrl.sv | 36 +++
 rtl/reorder_buffer.sv | 137 +++++++++++++
 tb/tb_reorder_buffer.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared types and sizing for the reorder buffer: index/count widths,
// instruction kind encodings and the flat entry field types.
package reorder_buffer_pkg;
  localparam int ROB_DEPTH = 32;
  localparam int ROB_IDX_W = $clog2(ROB_DEPTH);
  localparam int DATA_W    = 32;
  localparam int REG_IDX_W = 5;

  typedef logic [ROB_IDX_W-1:0] rob_idx_t;
  typedef logic [ROB_IDX_W:0]   rob_cnt_t;
  typedef logic [DATA_W-1:0]    data_t;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    KIND_ALU    = 2'b00,
    KIND_BRANCH = 2'b01,
    KIND_STORE  = 2'b10,
    KIND_LOAD   = 2'b11
  } kind_e;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam rob_cnt_t ROB_CNT_FULL = rob_cnt_t'(ROB_DEPTH);
endpackage

// File: rtl/reorder_buffer_if.sv
// Bundle of dispatch, operand query, writeback, commit and flush signals
// between the reorder buffer (slave) and the rest of the core (master).
interface reorder_buffer_if import reorder_buffer_pkg::*; ();
  logic             Dispatch_S;
  reg_idx_t         Dispatch_rd;
  logic [1:0]       Dispatch_kind;
  logic             ROB_full;
  rob_idx_t         ROB_freepos;
  rob_idx_t         Q1_pos, Q2_pos;
  logic             Q1_ready, Q2_ready;
  data_t            Q1_value, Q2_value;
  logic             ALU_S;
  rob_idx_t         ALU_pos;
  data_t            ALU_result;
  logic             ALU_jump_wrong;
  data_t            ALU_target;
  logic             LSB_S;
  rob_idx_t         LSB_pos;
  data_t            LSB_result;
  logic             ROB_write_S;
  reg_idx_t         ROB_rd;
  rob_idx_t         ROB_Reorder;
  data_t            ROB_result;
  logic             ROB_store_S;
  rob_idx_t         ROB_store_pos;
  logic             clr;
  data_t            clr_pc;

  modport slave (
    input  Dispatch_S, Dispatch_rd, Dispatch_kind, Q1_pos, Q2_pos,
           ALU_S, ALU_pos, ALU_result, ALU_jump_wrong, ALU_target,
           LSB_S, LSB_pos, LSB_result,
    output ROB_full, ROB_freepos, Q1_ready, Q2_ready, Q1_value, Q2_value,
           ROB_write_S, ROB_rd, ROB_Reorder, ROB_result,
           ROB_store_S, ROB_store_pos, clr, clr_pc
  );

  modport master (
    output Dispatch_S, Dispatch_rd, Dispatch_kind, Q1_pos, Q2_pos,
           ALU_S, ALU_pos, ALU_result, ALU_jump_wrong, ALU_target,
           LSB_S, LSB_pos, LSB_result,
    input  ROB_full, ROB_freepos, Q1_ready, Q2_ready, Q1_value, Q2_value,
           ROB_write_S, ROB_rd, ROB_Reorder, ROB_result,
           ROB_store_S, ROB_store_pos, clr, clr_pc
  );
endinterface

// File: rtl/reorder_buffer_ring_ctrl.sv
// Head/tail/occupancy bookkeeping for the circular buffer. The occupancy
// count, not pointer equality, separates full from empty.
module rob_ring_ctrl import reorder_buffer_pkg::*; (
  input  logic     clk,
  input  logic     rst,
  input  logic     alloc,
  input  logic     commit,
  input  logic     flush,
  output rob_idx_t head,
  output rob_idx_t tail,
  output logic     full
);
  rob_cnt_t count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (commit) head <= head + 1'b1;
      if (alloc)  tail <= tail + 1'b1;
      case ({alloc, commit})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full = (count == ROB_CNT_FULL);
endmodule

// File: rtl/reorder_buffer.sv
// In-order reorder buffer: allocates at tail, collects ALU/LSB results,
// serves operand values to dispatch and retires the head one per cycle.
module reorder_buffer import reorder_buffer_pkg::*; (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  reorder_buffer_if.slave  rob
);
  logic [ROB_DEPTH-1:0] busy_q, ready_q, jw_q;
  kind_e    kind_q   [ROB_DEPTH];
  reg_idx_t rd_q     [ROB_DEPTH];
  data_t    value_q  [ROB_DEPTH];
  data_t    target_q [ROB_DEPTH];

  rob_idx_t head, tail;
  logic     full;
  logic     live, commit, flush, alloc, alu_wb, lsb_wb;

  // Nothing moves while frozen or during the flush cycle itself.
  assign live   = rdy && !rob.clr;
  assign commit = live && busy_q[head] && ready_q[head];
  assign flush  = commit && (kind_q[head] == KIND_BRANCH) && jw_q[head];
  assign alloc  = live && !flush && rob.Dispatch_S && !full;
  assign alu_wb = live && !flush && rob.ALU_S && busy_q[rob.ALU_pos];
  assign lsb_wb = live && !flush && rob.LSB_S && busy_q[rob.LSB_pos];

  rob_ring_ctrl u_ring (
    .clk    (clk),
    .rst    (rst),
    .alloc  (alloc),
    .commit (commit),
    .flush  (flush),
    .head   (head),
    .tail   (tail),
    .full   (full)
  );

  assign rob.ROB_full    = full;
  assign rob.ROB_freepos = tail;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q  <= '0;
      ready_q <= '0;
    end else if (flush) begin
      busy_q  <= '0;
      ready_q <= '0;
    end else begin
      if (alu_wb) ready_q[rob.ALU_pos] <= ENABLE;
      if (lsb_wb) ready_q[rob.LSB_pos] <= ENABLE;
      if (commit) begin
        busy_q[head]  <= DISABLE;
        ready_q[head] <= DISABLE;
      end
      if (alloc) begin
        busy_q[tail]  <= ENABLE;
        ready_q[tail] <= DISABLE;
      end
    end
  end

  // Payload fields are only meaningful while busy, so they carry no reset.
  always_ff @(posedge clk) begin
    if (alu_wb) begin
      value_q[rob.ALU_pos]  <= rob.ALU_result;
      jw_q[rob.ALU_pos]     <= rob.ALU_jump_wrong;
      target_q[rob.ALU_pos] <= rob.ALU_target;
    end
    if (lsb_wb) value_q[rob.LSB_pos] <= rob.LSB_result;
    if (alloc) begin
      rd_q[tail]   <= rob.Dispatch_rd;
      kind_q[tail] <= kind_e'(rob.Dispatch_kind);
      jw_q[tail]   <= DISABLE;
    end
  end

  rob_idx_t [1:0] q_pos;
  logic     [1:0] q_rdy;
  data_t    [1:0] q_val;

  assign q_pos = {rob.Q2_pos, rob.Q1_pos};

  // Same-cycle writebacks bypass the entry array, ALU first.
  always_comb begin
    q_rdy = '0;
    q_val = '0;
    for (int q = 0; q < 2; q++) begin
      if (rob.ALU_S && rob.ALU_pos == q_pos[q]) begin
        q_rdy[q] = 1'b1;
        q_val[q] = rob.ALU_result;
      end else if (rob.LSB_S && rob.LSB_pos == q_pos[q]) begin
        q_rdy[q] = 1'b1;
        q_val[q] = rob.LSB_result;
      end else if (busy_q[q_pos[q]] && ready_q[q_pos[q]]) begin
        q_rdy[q] = 1'b1;
        q_val[q] = value_q[q_pos[q]];
      end
    end
  end

  assign rob.Q1_ready = q_rdy[0];
  assign rob.Q1_value = q_val[0];
  assign rob.Q2_ready = q_rdy[1];
  assign rob.Q2_value = q_val[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rob.clr           <= 1'b0;
      rob.clr_pc        <= '0;
      rob.ROB_write_S   <= 1'b0;
      rob.ROB_rd        <= '0;
      rob.ROB_Reorder   <= '0;
      rob.ROB_result    <= '0;
      rob.ROB_store_S   <= 1'b0;
      rob.ROB_store_pos <= '0;
    end else begin
      rob.clr         <= 1'b0;
      rob.ROB_write_S <= 1'b0;
      rob.ROB_store_S <= 1'b0;
      if (commit) begin
        if (kind_q[head] == KIND_STORE) begin
          rob.ROB_store_S   <= 1'b1;
          rob.ROB_store_pos <= head;
        end else if (rd_q[head] != '0) begin
          rob.ROB_write_S <= 1'b1;
          rob.ROB_rd      <= rd_q[head];
          rob.ROB_Reorder <= head;
          rob.ROB_result  <= value_q[head];
        end
        if (flush) begin
          rob.clr    <= 1'b1;
          rob.clr_pc <= target_q[head];
        end
      end
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: stimulus pushes expected commit events
// into a queue that a negedge monitor pops whenever a commit pulse appears.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rdy;

  reorder_buffer_if rob ();

  reorder_buffer dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .rob (rob)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic        st;
    logic        cl;
    logic [4:0]  rd;
    logic [4:0]  reorder;
    logic [31:0] result;
    logic [4:0]  spos;
    logic [31:0] pc;
  } ev_t;

  ev_t exp_q[$];
  int  n_chk  = 0;
  int  n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  function automatic ev_t wr_ev(input logic [4:0] rd, input logic [4:0] pos, input logic [31:0] res);
    ev_t e;
    e = '0;
    e.wr = 1'b1; e.rd = rd; e.reorder = pos; e.result = res;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rob.Dispatch_S = 1'b0; rob.Dispatch_rd = '0; rob.Dispatch_kind = 2'b00;
    rob.Q1_pos = '0; rob.Q2_pos = '0;
    rob.ALU_S = 1'b0; rob.ALU_pos = '0; rob.ALU_result = '0;
    rob.ALU_jump_wrong = 1'b0; rob.ALU_target = '0;
    rob.LSB_S = 1'b0; rob.LSB_pos = '0; rob.LSB_result = '0;
  endtask

  task automatic disp(input logic [4:0] rd, input logic [1:0] kind);
    rob.Dispatch_S = 1'b1; rob.Dispatch_rd = rd; rob.Dispatch_kind = kind;
  endtask

  task automatic alu(input logic [4:0] pos, input logic [31:0] res, input logic jw, input logic [31:0] tgt);
    rob.ALU_S = 1'b1; rob.ALU_pos = pos; rob.ALU_result = res;
    rob.ALU_jump_wrong = jw; rob.ALU_target = tgt;
  endtask

  task automatic lsb(input logic [4:0] pos, input logic [31:0] res);
    rob.LSB_S = 1'b1; rob.LSB_pos = pos; rob.LSB_result = res;
  endtask

  // Commit monitor
  initial begin : mon
    ev_t act, e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && (rob.ROB_write_S || rob.ROB_store_S || rob.clr)) begin
        act = '0;
        act.wr = rob.ROB_write_S;
        act.st = rob.ROB_store_S;
        act.cl = rob.clr;
        if (act.wr) begin
          act.rd = rob.ROB_rd; act.reorder = rob.ROB_Reorder; act.result = rob.ROB_result;
        end
        if (act.st) act.spos = rob.ROB_store_pos;
        if (act.cl) act.pc = rob.clr_pc;
        n_chk++;
        if (exp_q.size() == 0) begin
          $display("FAIL commit_event: got unexpected %h, expected none", act);
        end else begin
          e = exp_q.pop_front();
          if (act === e) n_pass++;
          else $display("FAIL commit_event: got %h, expected %h", act, e);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    rdy = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_full",    32'(rob.ROB_full), 32'd0);
    chk("rst_freepos", 32'(rob.ROB_freepos), 32'd0);
    chk("rst_pulses",  32'({rob.clr, rob.ROB_write_S, rob.ROB_store_S}), 32'd0);
    chk("rst_clr_pc",  rob.clr_pc, 32'd0);
    chk("rst_rd",      32'({rob.ROB_rd, rob.ROB_Reorder, rob.ROB_store_pos}), 32'd0);
    chk("rst_result",  rob.ROB_result, 32'd0);
    rst = 1'b1;
    tick();

    // In-order commit with out-of-order writeback
    disp(5'd1, 2'b00); tick();
    disp(5'd2, 2'b00); tick();
    disp(5'd3, 2'b00); tick();
    rob.Dispatch_S = 1'b0;
    chk("freepos_3", 32'(rob.ROB_freepos), 32'd3);
    alu(5'd1, 32'd7, 1'b0, 32'd0); tick();
    exp_q.push_back(wr_ev(5'd1, 5'd0, 32'd5));
    exp_q.push_back(wr_ev(5'd2, 5'd1, 32'd7));
    alu(5'd0, 32'd5, 1'b0, 32'd0);
    rob.Q1_pos = 5'd1; rob.Q2_pos = 5'd2;
    #1;
    chk("q1_entry_rdy", 32'(rob.Q1_ready), 32'd1);
    chk("q1_entry_val", rob.Q1_value, 32'd7);
    chk("q2_notready",  32'({rob.Q2_ready, 1'b0}) | 32'(rob.Q2_value != 0), 32'd0);
    tick();
    rob.ALU_S = 1'b0;
    repeat (3) tick();

    // Bypass priority on a tag with no live entry
    alu(5'd4, 32'hDEAD, 1'b0, 32'd0);
    lsb(5'd4, 32'hBEEF);
    rob.Q1_pos = 5'd4; rob.Q2_pos = 5'd6;
    #1;
    chk("byp_alu_rdy", 32'(rob.Q1_ready), 32'd1);
    chk("byp_alu_val", rob.Q1_value, 32'hDEAD);
    chk("byp_none",    32'(rob.Q2_ready), 32'd0);
    rob.ALU_S = 1'b0;
    #1;
    chk("byp_lsb_val", rob.Q1_value, 32'hBEEF);
    tick();
    idle();

    // Reset with three busy entries
    disp(5'd4, 2'b00); tick();
    disp(5'd5, 2'b00); tick();
    rob.Dispatch_S = 1'b0;
    chk("freepos_5", 32'(rob.ROB_freepos), 32'd5);
    rst = 1'b0;
    #1;
    chk("mrst_full",    32'(rob.ROB_full), 32'd0);
    chk("mrst_freepos", 32'(rob.ROB_freepos), 32'd0);
    chk("mrst_pulses",  32'({rob.clr, rob.ROB_write_S, rob.ROB_store_S}), 32'd0);
    chk("mrst_rd",      32'(rob.ROB_rd), 32'd0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // Fill, overflow drop, wrap
    for (int i = 0; i < 31; i++) begin
      disp(5'd0, 2'b00); tick();
    end
    chk("fill31_full",    32'(rob.ROB_full), 32'd0);
    chk("fill31_freepos", 32'(rob.ROB_freepos), 32'd31);
    tick();
    chk("fill32_full",    32'(rob.ROB_full), 32'd1);
    chk("fill32_freepos", 32'(rob.ROB_freepos), 32'd0);
    lsb(5'd0, 32'h11); tick();
    chk("drop33_full",    32'(rob.ROB_full), 32'd1);
    chk("drop33_freepos", 32'(rob.ROB_freepos), 32'd0);
    lsb(5'd1, 32'h22); tick();
    chk("commit_full_freepos", 32'({rob.ROB_full, rob.ROB_freepos}), 32'd0);
    rob.LSB_S = 1'b0; tick();
    chk("commit_alloc_full",    32'(rob.ROB_full), 32'd0);
    chk("commit_alloc_freepos", 32'(rob.ROB_freepos), 32'd1);
    tick();
    chk("refill_full",    32'(rob.ROB_full), 32'd1);
    chk("refill_freepos", 32'(rob.ROB_freepos), 32'd2);
    idle();
    rst = 1'b0; tick(); rst = 1'b1; tick();

    // Mispredict at head
    disp(5'd1, 2'b01); tick();
    disp(5'd2, 2'b00); tick();
    disp(5'd3, 2'b00);
    alu(5'd0, 32'h44, 1'b1, 32'h100);
    lsb(5'd1, 32'd9);
    begin
      ev_t e;
      e = wr_ev(5'd1, 5'd0, 32'h44);
      e.cl = 1'b1; e.pc = 32'h100;
      exp_q.push_back(e);
    end
    tick();
    disp(5'd9, 2'b00);
    alu(5'd2, 32'h55, 1'b0, 32'd0);
    rob.LSB_S = 1'b0;
    tick();
    chk("flush_clr",     32'(rob.clr), 32'd1);
    chk("flush_freepos", 32'(rob.ROB_freepos), 32'd0);
    chk("flush_full",    32'(rob.ROB_full), 32'd0);
    alu(5'd0, 32'h66, 1'b0, 32'd0);
    tick();
    chk("clrcyc_freepos", 32'(rob.ROB_freepos), 32'd0);
    idle();
    rob.Q1_pos = 5'd1;
    #1;
    chk("flush_q_ready", 32'(rob.Q1_ready), 32'd0);
    tick();

    // Load then store at head, with a freeze before the store retires
    disp(5'd7, 2'b11); tick();
    disp(5'd0, 2'b10);
    lsb(5'd0, 32'h77);
    exp_q.push_back(wr_ev(5'd7, 5'd0, 32'h77));
    tick();
    rob.Dispatch_S = 1'b0;
    lsb(5'd1, 32'hAB);
    tick();
    rob.LSB_S = 1'b0;
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frozen_store", 32'({rob.ROB_store_S, rob.ROB_write_S}), 32'd0);
    end
    begin
      ev_t e;
      e = '0;
      e.st = 1'b1; e.spos = 5'd1;
      exp_q.push_back(e);
    end
    rdy = 1'b1;
    tick();
    chk("store_pulse", 32'({rob.ROB_store_S, rob.ROB_write_S}), 32'd2);
    repeat (3) tick();

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
